// File: rtl/router_flit_injector.sv
// Credit-based flit injector: buffers payload words from a core and frames them
// into SINGLE/HEAD/BODY/TAIL flits for one router input port.
module router_flit_injector #(
   parameter int FLIT_WIDTH  = 32,
   parameter int DST_BITS    = 3,
   parameter int NUM_CREDITS = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [FLIT_WIDTH-2-DST_BITS-1:0]     in_data,
   input  logic [DST_BITS-1:0]                  in_dst,
   input  logic                                 in_last,
   output logic [FLIT_WIDTH-1:0]                out_data,
   output logic                                 out_valid,
   input  logic                                 credit_in,
   output logic [$clog2(NUM_CREDITS+1)-1:0]     credit_cnt,
   output logic                                 pkt_sent,
   output logic                                 credit_err
);

   localparam int PAY_W  = FLIT_WIDTH - 2 - DST_BITS;
   localparam int ENT_W  = PAY_W + DST_BITS + 2;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;
   localparam int CRD_W  = $clog2(NUM_CREDITS + 1);

   localparam logic [1:0] T_SINGLE = 2'b00;
   localparam logic [1:0] T_HEAD   = 2'b01;
   localparam logic [1:0] T_BODY   = 2'b10;
   localparam logic [1:0] T_TAIL   = 2'b11;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wptr;
   logic [PTR_W-1:0]      r_rptr;
   logic [FCNT_W-1:0]     r_count;
   logic                  r_first_in;
   state_t                r_state;
   logic [DST_BITS-1:0]   r_dst;
   logic [FLIT_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;
   logic                  r_pkt_sent;
   logic [CRD_W-1:0]      r_credit_cnt;
   logic                  r_credit_err;

   logic                  w_in_ready;
   logic                  w_push;
   logic                  w_send;
   logic [ENT_W-1:0]      w_head;
   logic                  w_head_last;
   logic                  w_head_first;
   logic [DST_BITS-1:0]   w_head_dst;
   logic [PAY_W-1:0]      w_head_data;

   assign w_in_ready   = (r_count < FCNT_W'(FIFO_DEPTH));
   assign w_push       = in_valid && w_in_ready;
   // Registered credit count only: a same-cycle credit_in cannot enable a send.
   assign w_send       = (r_count != {FCNT_W{1'b0}}) && (r_credit_cnt != {CRD_W{1'b0}});
   assign w_head       = r_mem[r_rptr];
   assign w_head_last  = w_head[ENT_W-1];
   assign w_head_first = w_head[ENT_W-2];
   assign w_head_dst   = w_head[PAY_W +: DST_BITS];
   assign w_head_data  = w_head[PAY_W-1:0];

   assign in_ready   = w_in_ready;
   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign pkt_sent   = r_pkt_sent;
   assign credit_cnt = r_credit_cnt;
   assign credit_err = r_credit_err;

   // Payload buffer: storage, pointers, occupancy and input-side first flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= {ENT_W{1'b0}};
         end
         r_wptr     <= {PTR_W{1'b0}};
         r_rptr     <= {PTR_W{1'b0}};
         r_count    <= {FCNT_W{1'b0}};
         r_first_in <= 1'b1;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= {in_last, r_first_in, in_dst, in_data};
            r_wptr        <= r_wptr + PTR_W'(1);
            r_first_in    <= in_last;
         end else begin
            r_first_in    <= r_first_in;
         end
         if (w_send) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end else begin
            r_rptr <= r_rptr;
         end
         case ({w_push, w_send})
            2'b10:   r_count <= r_count + FCNT_W'(1);
            2'b01:   r_count <= r_count - FCNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Output framing FSM with registered flit, valid and packet-sent pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_dst       <= {DST_BITS{1'b0}};
         r_out_data  <= {FLIT_WIDTH{1'b0}};
         r_out_valid <= 1'b0;
         r_pkt_sent  <= 1'b0;
      end else if (w_send) begin
         r_out_valid <= 1'b1;
         r_pkt_sent  <= w_head_last;
         case (r_state)
            S_IDLE: begin
               if (w_head_last) begin
                  r_out_data <= {T_SINGLE, w_head_dst, w_head_data};
                  r_state    <= S_IDLE;
               end else begin
                  r_out_data <= {T_HEAD, w_head_dst, w_head_data};
                  r_dst      <= w_head_dst;
                  r_state    <= S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               // A first-flagged word here cannot occur; restart framing if it does.
               if (w_head_first) begin
                  r_out_data <= {(w_head_last ? T_SINGLE : T_HEAD), w_head_dst, w_head_data};
                  r_dst      <= w_head_dst;
                  r_state    <= w_head_last ? S_IDLE : S_ACTIVE;
               end else if (w_head_last) begin
                  r_out_data <= {T_TAIL, r_dst, w_head_data};
                  r_state    <= S_IDLE;
               end else begin
                  r_out_data <= {T_BODY, r_dst, w_head_data};
                  r_state    <= S_ACTIVE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_pkt_sent  <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end else begin
         r_out_valid <= 1'b0;
         r_pkt_sent  <= 1'b0;
      end
   end

   // Credit pool with saturation and sticky overflow flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_credit_cnt <= CRD_W'(NUM_CREDITS);
         r_credit_err <= 1'b0;
      end else if (w_send && !credit_in) begin
         r_credit_cnt <= r_credit_cnt - CRD_W'(1);
      end else if (credit_in && !w_send) begin
         if (r_credit_cnt == CRD_W'(NUM_CREDITS)) begin
            r_credit_err <= 1'b1;
         end else begin
            r_credit_cnt <= r_credit_cnt + CRD_W'(1);
         end
      end else begin
         r_credit_cnt <= r_credit_cnt;
      end
   end

endmodule

// File: tb/tb_router_flit_injector.sv
// Directed self-checking bench for router_flit_injector (default parameters).
module tb_router_flit_injector;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [26:0] in_data;
   logic [2:0]  in_dst;
   logic        in_last;
   logic [31:0] out_data;
   logic        out_valid;
   logic        credit_in;
   logic [2:0]  credit_cnt;
   logic        pkt_sent;
   logic        credit_err;

   int n_checks = 0;
   int n_errors = 0;

   router_flit_injector #(
      .FLIT_WIDTH(32), .DST_BITS(3), .NUM_CREDITS(4), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_dst(in_dst), .in_last(in_last),
      .out_data(out_data), .out_valid(out_valid), .credit_in(credit_in),
      .credit_cnt(credit_cnt), .pkt_sent(pkt_sent), .credit_err(credit_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [1:0] t, input logic [2:0] d, input logic [26:0] p);
      return {t, d, p};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] d, input logic [26:0] p, input logic l);
      in_valid = v;
      in_dst   = d;
      in_data  = p;
      in_last  = l;
   endtask

   initial begin
      reset = 1'b0; credit_in = 1'b0;
      drive(1'b0, 3'd0, 27'h0, 1'b0);
      step(); step();
      reset = 1'b1;

      // 1: reset values, then a single-flit packet
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_credit_cnt", {29'd0, credit_cnt}, 32'd4);
      chk("rst_credit_err", {31'd0, credit_err}, 32'd0);
      drive(1'b1, 3'd5, 27'h1234, 1'b1);
      step();
      drive(1'b0, 3'd0, 27'h0, 1'b0);
      chk("t1_no_early_valid", {31'd0, out_valid}, 32'd0);
      step();
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_data", out_data, mk(2'b00, 3'd5, 27'h1234));
      chk("t1_pkt_sent", {31'd0, pkt_sent}, 32'd1);
      chk("t1_credit", {29'd0, credit_cnt}, 32'd3);
      step();
      chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
      chk("t1_pkt_drop", {31'd0, pkt_sent}, 32'd0);
      chk("t1_data_hold", out_data, mk(2'b00, 3'd5, 27'h1234));

      // 2: restore one credit, then 3-word packet to dst 2
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      chk("t2_credit_restore", {29'd0, credit_cnt}, 32'd4);
      drive(1'b1, 3'd2, 27'h0a1, 1'b0);
      step();
      drive(1'b1, 3'd2, 27'h0a2, 1'b0);
      step();
      chk("t2_head", out_data, mk(2'b01, 3'd2, 27'h0a1));
      chk("t2_head_pkt", {31'd0, pkt_sent}, 32'd0);
      chk("t2_head_cnt", {29'd0, credit_cnt}, 32'd3);
      drive(1'b1, 3'd2, 27'h0a3, 1'b1);
      step();
      drive(1'b0, 3'd0, 27'h0, 1'b0);
      chk("t2_body", out_data, mk(2'b10, 3'd2, 27'h0a2));
      chk("t2_body_pkt", {31'd0, pkt_sent}, 32'd0);
      step();
      chk("t2_tail", out_data, mk(2'b11, 3'd2, 27'h0a3));
      chk("t2_tail_valid", {31'd0, out_valid}, 32'd1);
      chk("t2_tail_pkt", {31'd0, pkt_sent}, 32'd1);
      chk("t2_tail_cnt", {29'd0, credit_cnt}, 32'd1);

      // 3: restore to 4 credits, stream singles until credits exhausted and FIFO full
      credit_in = 1'b1;
      step(); step(); step();
      credit_in = 1'b0;
      chk("t3_credit_full", {29'd0, credit_cnt}, 32'd4);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 3'd7, 27'h100 + 27'(i), 1'b1);
         step();
         if (i >= 1 && i <= 4) begin
            chk("t3_stream_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_stream_data", out_data, mk(2'b00, 3'd7, 27'h100 + 27'(i - 1)));
            chk("t3_stream_cnt", {29'd0, credit_cnt}, 32'(4 - i));
         end else if (i >= 5) begin
            chk("t3_stall_valid", {31'd0, out_valid}, 32'd0);
         end
      end
      drive(1'b0, 3'd0, 27'h0, 1'b0);
      chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
      chk("t3_zero_cnt", {29'd0, credit_cnt}, 32'd0);
      credit_in = 1'b1;
      step();
      credit_in = 1'b0;
      chk("t3_pulse_cnt", {29'd0, credit_cnt}, 32'd1);
      chk("t3_pulse_no_send", {31'd0, out_valid}, 32'd0);
      step();
      chk("t3_one_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_one_data", out_data, mk(2'b00, 3'd7, 27'h104));
      chk("t3_one_cnt", {29'd0, credit_cnt}, 32'd0);
      chk("t3_ready_again", {31'd0, in_ready}, 32'd1);
      step();
      chk("t3_only_one", {31'd0, out_valid}, 32'd0);

      reset = 1'b0;
      #2;
      reset = 1'b1;

      // 4: send coinciding with credit return, then overflow
      drive(1'b1, 3'd3, 27'h200, 1'b1);
      step();
      drive(1'b1, 3'd3, 27'h201, 1'b1);
      step();
      chk("t4_cnt3", {29'd0, credit_cnt}, 32'd3);
      drive(1'b0, 3'd0, 27'h0, 1'b0);
      step();
      chk("t4_cnt2", {29'd0, credit_cnt}, 32'd2);
      drive(1'b1, 3'd3, 27'h202, 1'b1);
      step();
      drive(1'b0, 3'd0, 27'h0, 1'b0);
      credit_in = 1'b1;
      step();
      chk("t4_both_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_both_data", out_data, mk(2'b00, 3'd3, 27'h202));
      chk("t4_both_cnt", {29'd0, credit_cnt}, 32'd2);
      chk("t4_no_err_yet", {31'd0, credit_err}, 32'd0);
      step(); step();
      chk("t4_cnt4", {29'd0, credit_cnt}, 32'd4);
      chk("t4_no_err_at4", {31'd0, credit_err}, 32'd0);
      step();
      credit_in = 1'b0;
      chk("t4_sat_cnt", {29'd0, credit_cnt}, 32'd4);
      chk("t4_err_set", {31'd0, credit_err}, 32'd1);
      step(); step();
      chk("t4_err_sticky", {31'd0, credit_err}, 32'd1);

      // 5: reset after HEAD sent drops the packet
      drive(1'b1, 3'd3, 27'h050, 1'b0);
      step();
      drive(1'b1, 3'd3, 27'h051, 1'b0);
      step();
      drive(1'b0, 3'd0, 27'h0, 1'b0);
      chk("t5_head", out_data, mk(2'b01, 3'd3, 27'h050));
      reset = 1'b0;
      #1;
      chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_rst_data", out_data, 32'd0);
      chk("t5_rst_cnt", {29'd0, credit_cnt}, 32'd4);
      chk("t5_rst_ready", {31'd0, in_ready}, 32'd1);
      chk("t5_rst_err", {31'd0, credit_err}, 32'd0);
      reset = 1'b1;
      step();
      chk("t5_fifo_empty", {31'd0, out_valid}, 32'd0);
      drive(1'b1, 3'd4, 27'h060, 1'b1);
      step();
      drive(1'b0, 3'd0, 27'h0, 1'b0);
      step();
      chk("t5_new_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_new_single", out_data, mk(2'b00, 3'd4, 27'h060));

      // 6: destination changes on body words are ignored
      drive(1'b1, 3'd1, 27'h070, 1'b0);
      step();
      drive(1'b1, 3'd6, 27'h071, 1'b0);
      step();
      chk("t6_head", out_data, mk(2'b01, 3'd1, 27'h070));
      drive(1'b1, 3'd6, 27'h072, 1'b1);
      step();
      drive(1'b0, 3'd0, 27'h0, 1'b0);
      chk("t6_body", out_data, mk(2'b10, 3'd1, 27'h071));
      step();
      chk("t6_tail", out_data, mk(2'b11, 3'd1, 27'h072));
      chk("t6_tail_pkt", {31'd0, pkt_sent}, 32'd1);
      chk("t6_cnt0", {29'd0, credit_cnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
